// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream from the program source into the instruction encoder.
// The master drives the fields, in_valid and in_last; the encoder returns in_ready.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;

    modport master (
        output in_valid, in_last, op, funct3, funct7, rd, rs1, rs2, imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, op, funct3, funct7, rd, rs1, rs2, imm,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs RV32I field bundles into words and writes them to imem at consecutive addresses, holding the core until done.
// One registered cycle from accept to imem write; in_ready is high only while loading, one bundle per cycle.
module instr_encoder_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   imem_we,
    output logic [AW-1:0]          imem_addr,
    output logic [31:0]            imem_wd,
    output logic                   core_hold,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
    typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_X} fmt_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t      state;
    logic [AW:0] cnt;
    fmt_t        fmt;
    logic        is_shift;
    logic        imm_ok;
    logic [31:0] word;
    logic        accept;

    assign bus.in_ready = (state == LOAD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_shift     = (bus.op == 7'b0010011) && (bus.funct3[1:0] == 2'b01);

    always_comb begin
        fmt = F_X;
        case (bus.op)
            7'b0000011, 7'b0010011, 7'b1100111: fmt = F_I;
            7'b0100011:                         fmt = F_S;
            7'b0110011:                         fmt = F_R;
            7'b1100011:                         fmt = F_B;
            7'b1101111:                         fmt = F_J;
            7'b0110111, 7'b0010111:             fmt = F_U;
            default:                            fmt = F_X;
        endcase
    end

    // Range checks: the bits above the field's sign bit must all equal it.
    always_comb begin
        imm_ok = 1'b0;
        case (fmt)
            F_R: imm_ok = 1'b1;
            F_I: imm_ok = is_shift ? (bus.imm[31:5] == '0)
                                   : (&bus.imm[31:11] || ~|bus.imm[31:11]);
            F_S: imm_ok = &bus.imm[31:11] || ~|bus.imm[31:11];
            F_B: imm_ok = (&bus.imm[31:12] || ~|bus.imm[31:12]) && !bus.imm[0];
            F_J: imm_ok = (&bus.imm[31:20] || ~|bus.imm[31:20]) && !bus.imm[0];
            F_U: imm_ok = (bus.imm[11:0] == '0);
            default: imm_ok = 1'b0;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt)
            F_R: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.op};
            F_I: word = (is_shift && bus.funct3[2])
                      ? {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.op}
                      : {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
            F_S: word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.op};
            F_B: word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                         bus.imm[4:1], bus.imm[11], bus.op};
            F_U: word = {bus.imm[31:12], bus.rd, bus.op};
            F_J: word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.op};
            default: word = '0;
        endcase
    end

    // done/core_hold follow the state one cycle late so the last write lands before release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            imem_we   <= 1'b0;
            done      <= (state == DONE);
            core_hold <= (state != DONE);
            case (state)
                IDLE: if (start) state <= LOAD;
                LOAD: begin
                    if (accept) begin
                        if (fmt == F_X) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            state    <= ERR;
                        end else if (!imm_ok) begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                            state    <= ERR;
                        end else if (cnt == FULL) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                            state    <= ERR;
                        end else begin
                            imem_we   <= 1'b1;
                            imem_addr <= cnt[AW-1:0];
                            imem_wd   <= word;
                            cnt       <= cnt + (AW+1)'(1);
                            if (bus.in_last) state <= DONE;
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule
